peg_l2_rs_rmii_tx_sched: RTL and testbench
==========================================

Name: peg_l2_rs_rmii_tx_sched

Overview:
Transmit-side RMII reconciliation sequencer. It accepts MAC TX packet words and schedules the RMII TX pins through four phases: preamble/SFD insertion, payload dibit serialisation, underrun handling and inter-frame gap enforcement. It supports 10 and 100 Mbps modes. It sits between the MAC TX packet interface and the PHY, and is the transmit counterpart of the RMII RX RS.

Parameters:
PKT_DATA_W, 64, packet word width in bits (multiple of 8); serialised LSB-dibit first, PKT_DATA_W/2 dibits per word
IFG_DIBITS, 48, minimum inter-frame gap in dibit periods (12 bytes)
NBYTES_W, $clog2(PKT_DATA_W/8), width of pkt_nbytes

Ports:
rmii_ref_clk  input  1  50 MHz RMII reference clock; the only clock
rst  input  1  synchronous, active-high reset
config_rs_mii_speed_100_n_10  input  1  1 = 100 Mbps, 0 = 10 Mbps; sampled only in IDLE_S
pkt_valid  input  1  MAC word valid
pkt_sop  input  1  first word of frame
pkt_eop  input  1  last word of frame
pkt_data  input  PKT_DATA_W  payload word, byte 0 in [7:0]
pkt_nbytes  input  NBYTES_W  valid bytes in the eop word; 0 = full word
pkt_error  input  1  frame error flag; sampled on accepted words
pkt_ready  output  1  word accept; transfer = pkt_valid & pkt_ready
rmii_tx_en  output  1  RMII transmit enable (registered)
rmii_txd  output  2  RMII transmit dibit (registered)
tx_underrun  output  1  one-cycle pulse when a frame is aborted for data starvation
tx_busy  output  1  high in every state except IDLE_S

Behaviour:
- Reset: state IDLE_S. rmii_tx_en, rmii_txd, tx_underrun and pkt_ready are 0. All counters and the shift register are 0.
- Dibit strobe (step):
  - 100 Mbps mode (latched): step fires every cycle.
  - 10 Mbps mode (latched): a 4-bit counter runs 0..9 and step fires at count 9. The counter clears on leaving IDLE_S, so every dibit is held exactly 10 cycles.
- Speed latch: config_rs_mii_speed_100_n_10 is captured on the IDLE_S->PRE_S transition. A config change mid-frame has no effect until the next IDLE_S exit.
- IDLE_S:
  - pkt_valid & pkt_sop -> PRE_S. The word is not consumed (pkt_ready=0).
  - pkt_valid & ~pkt_sop -> pkt_ready=1 and the word is discarded (stray word).
- PRE_S:
  - Emits 31 dibits of 2'b01 (0x55 x7 plus the low 3 dibits of the SFD), then 2'b11 (last dibit of SFD 0xD5), for 32 dibits total.
  - Latency: sop seen in cycle N gives rmii_tx_en=1 with rmii_txd=2'b01 in cycle N+1.
  - On the step of dibit 31, pkt_ready=1. The word is loaded into the shift register and the state moves to DATA_S.
- DATA_S:
  - Outputs {rmii_tx_en=1, shift[1:0]}; the register shifts right 2 bits per step.
  - Dibit budget is PKT_DATA_W/2 per word; an eop word gets 4*pkt_nbytes (4*PKT_DATA_W/8 when pkt_nbytes=0).
  - On the step of the last dibit of a non-eop word, pkt_ready=1:
    - If pkt_valid, the next word loads seamlessly with no gap dibit.
    - If ~pkt_valid, the frame underruns: tx_underrun pulses, rmii_tx_en drops on the next cycle, and the state moves to DROP_S.
  - On the step of the last dibit of the eop word -> IFG_S, and rmii_tx_en=0 from the next cycle.
  - A new pkt_sop accepted mid-frame is treated as data. The MAC is responsible for framing.
- DROP_S:
  - pkt_ready=1 and all words are discarded.
  - On an accepted eop word -> IFG_S.
  - rmii_tx_en=0 throughout.
- IFG_S:
  - rmii_tx_en=0 and rmii_txd=2'b00.
  - Counts IFG_DIBITS steps, then -> IDLE_S. No pkt_ready in this state.
- rmii_txd is 2'b00 whenever rmii_tx_en=0.
- pkt_error: if set on any accepted data word, the rest of that frame is still sent. pkt_error only affects the stats counter (see Optional Feature).
- Reset asserted mid-frame: next cycle rmii_tx_en=0 and the state is IDLE_S. No IFG is enforced after reset.

Optional Feature:
Macro: PEG_L2_RMII_TX_STATS_EN
- Defined: adds three 16-bit saturating output counters:
  - stat_tx_frames: frames completed through IFG entry from DATA_S.
  - stat_tx_underruns: count of underrun aborts.
  - stat_tx_err_frames: completed frames that had any accepted word with pkt_error=1.
  - All three clear on rst.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

Test Plan:
- 100 Mbps, PKT_DATA_W=64, a single eop+sop word 0x0807060504030201 with pkt_nbytes=0 -> rmii_tx_en high for 64 cycles (32 preamble + 32 data). First data dibit 2'b01, IFG of 48 cycles with tx_busy high, then IDLE.
- 10 Mbps, same frame -> each dibit held 10 cycles and rmii_tx_en high for 640 cycles. Toggling speed config mid-frame changes nothing.
- 100 Mbps, 2-word frame with pkt_valid low at the word-0 boundary -> tx_underrun 1-cycle pulse, rmii_tx_en low the next cycle, and the remaining word and eop drained with pkt_ready=1.
- eop word with pkt_nbytes=3 -> exactly 12 data dibits after the SFD, then tx_en falls.
- Back-to-back frames with sop held valid during IFG -> the second preamble starts exactly 48 steps after the first tx_en falls. A stray non-sop word in IDLE is consumed and not sent.
- rst pulsed mid-payload -> the next cycle shows rmii_tx_en=0, pkt_ready=0 and tx_busy=0. With PEG_L2_RMII_TX_STATS_EN defined, all stat counters read 0.

Source files
------------

// File: rtl/peg_l2_rs_rmii_tx_sched.sv
// peg_l2_rs_rmii_tx_sched: transmit-side RMII reconciliation sequencer.
// Takes MAC TX packet words and drives the RMII TX pins through
// preamble/SFD, LSB-first dibit payload, underrun abort and inter-frame gap.
// 10 and 100 Mbps modes; the speed is latched when a frame starts.
// Optional frame statistics counters: define PEG_L2_RMII_TX_STATS_EN.
module peg_l2_rs_rmii_tx_sched #(
  parameter int unsigned PKT_DATA_W = 64,
  parameter int unsigned IFG_DIBITS = 48,
  parameter int unsigned NBYTES_W   = $clog2(PKT_DATA_W/8)
) (
  input  logic                  rmii_ref_clk,
  input  logic                  rst,
  input  logic                  config_rs_mii_speed_100_n_10,
  input  logic                  pkt_valid,
  input  logic                  pkt_sop,
  input  logic                  pkt_eop,
  input  logic [PKT_DATA_W-1:0] pkt_data,
  input  logic [NBYTES_W-1:0]   pkt_nbytes,
  input  logic                  pkt_error,
  output logic                  pkt_ready,
  output logic                  rmii_tx_en,
  output logic [1:0]            rmii_txd,
  output logic                  tx_underrun,
  output logic                  tx_busy
`ifdef PEG_L2_RMII_TX_STATS_EN
  ,
  output logic [15:0]           stat_tx_frames,
  output logic [15:0]           stat_tx_underruns,
  output logic [15:0]           stat_tx_err_frames
`endif
);

  localparam int unsigned DIBITS_PER_WORD = PKT_DATA_W / 2;
  // 4*nbytes dibits fits exactly in NBYTES_W+2 bits
  localparam int unsigned DCNT_W          = NBYTES_W + 2;
  localparam int unsigned IFG_W           = $clog2(IFG_DIBITS + 1);

  localparam logic [DCNT_W-1:0] FULL_LAST = DCNT_W'(DIBITS_PER_WORD - 1);
  localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_DIBITS - 1);
  localparam logic [4:0]        PRE_LAST  = 5'd31;
  localparam logic [3:0]        DIV_LAST  = 4'd9;

  typedef enum logic [2:0] {
    IDLE_S,
    PRE_S,
    DATA_S,
    DROP_S,
    IFG_S
  } state_t;

  state_t                state_q, state_nxt;
  logic                  speed100_q, speed100_nxt;
  logic [3:0]            div_q, div_nxt;
  logic [4:0]            pre_q, pre_nxt;
  logic [DCNT_W-1:0]     dcnt_q, dcnt_nxt;
  logic [DCNT_W-1:0]     last_q, last_nxt;
  logic                  eop_q, eop_nxt;
  logic [IFG_W-1:0]      ifg_q, ifg_nxt;
  logic [PKT_DATA_W-1:0] shift_q, shift_nxt;
  logic                  tx_en_nxt;
  logic [1:0]            txd_nxt;

  logic                  step;
  logic                  start_frame;
  logic                  load_word;
  logic                  underrun;
  logic                  frame_done;

  // Index of the last dibit to send from a freshly accepted word.
  function automatic logic [DCNT_W-1:0] word_last(input logic                eop,
                                                  input logic [NBYTES_W-1:0] nb);
    if (eop && (nb != '0)) begin
      word_last = {nb, 2'b00} - DCNT_W'(1);
    end else begin
      word_last = FULL_LAST;
    end
  endfunction

  // Dibit strobe: every cycle at 100 Mbps, every tenth cycle at 10 Mbps.
  always_comb begin
    step = speed100_q | (div_q == DIV_LAST);
  end

  // Busy everywhere except idle.
  always_comb begin
    tx_busy = (state_q != IDLE_S);
  end

  // Next-state, pin and handshake decode.
  always_comb begin
    state_nxt    = state_q;
    speed100_nxt = speed100_q;
    div_nxt      = (state_q == IDLE_S || step) ? '0 : div_q + 4'd1;
    pre_nxt      = pre_q;
    dcnt_nxt     = dcnt_q;
    last_nxt     = last_q;
    eop_nxt      = eop_q;
    ifg_nxt      = ifg_q;
    shift_nxt    = shift_q;
    tx_en_nxt    = rmii_tx_en;
    txd_nxt      = rmii_txd;
    pkt_ready    = 1'b0;
    start_frame  = 1'b0;
    load_word    = 1'b0;
    underrun     = 1'b0;
    frame_done   = 1'b0;

    unique case (state_q)
      IDLE_S: begin
        if (pkt_valid) begin
          if (pkt_sop) begin
            start_frame = 1'b1;
          end else begin
            pkt_ready = 1'b1;
          end
        end
      end

      PRE_S: begin
        if (step) begin
          if (pre_q == PRE_LAST) begin
            pkt_ready = 1'b1;
            if (pkt_valid) begin
              load_word = 1'b1;
            end else begin
              underrun = 1'b1;
            end
          end else begin
            pre_nxt = pre_q + 5'd1;
            txd_nxt = (pre_q == PRE_LAST - 5'd1) ? 2'b11 : 2'b01;
          end
        end
      end

      DATA_S: begin
        if (step) begin
          if (dcnt_q == last_q) begin
            if (eop_q) begin
              frame_done = 1'b1;
              state_nxt  = IFG_S;
              tx_en_nxt  = 1'b0;
              txd_nxt    = 2'b00;
              ifg_nxt    = '0;
            end else begin
              pkt_ready = 1'b1;
              if (pkt_valid) begin
                load_word = 1'b1;
              end else begin
                underrun = 1'b1;
              end
            end
          end else begin
            dcnt_nxt  = dcnt_q + DCNT_W'(1);
            txd_nxt   = shift_q[1:0];
            shift_nxt = shift_q >> 2;
          end
        end
      end

      DROP_S: begin
        pkt_ready = 1'b1;
        if (pkt_valid && pkt_eop) begin
          state_nxt = IFG_S;
          ifg_nxt   = '0;
          div_nxt   = '0;
        end
      end

      IFG_S: begin
        if (step) begin
          if (ifg_q == IFG_LAST) begin
            // A sop already waiting starts its preamble on the step that
            // closes the gap, so the gap is exactly IFG_DIBITS long.
            if (pkt_valid && pkt_sop) begin
              start_frame = 1'b1;
            end else begin
              state_nxt = IDLE_S;
            end
          end else begin
            ifg_nxt = ifg_q + IFG_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE_S;
        tx_en_nxt = 1'b0;
        txd_nxt   = 2'b00;
      end
    endcase

    if (start_frame) begin
      state_nxt    = PRE_S;
      speed100_nxt = config_rs_mii_speed_100_n_10;
      div_nxt      = '0;
      pre_nxt      = '0;
      tx_en_nxt    = 1'b1;
      txd_nxt      = 2'b01;
    end

    // The first dibit of a new word goes straight to the pins; the rest
    // waits in the shift register, so words follow with no gap dibit.
    if (load_word) begin
      state_nxt = DATA_S;
      dcnt_nxt  = '0;
      last_nxt  = word_last(pkt_eop, pkt_nbytes);
      eop_nxt   = pkt_eop;
      shift_nxt = pkt_data >> 2;
      tx_en_nxt = 1'b1;
      txd_nxt   = pkt_data[1:0];
    end

    if (underrun) begin
      state_nxt = DROP_S;
      tx_en_nxt = 1'b0;
      txd_nxt   = 2'b00;
    end
  end

  always_comb begin
    tx_underrun = underrun;
  end

  // State, counters, shift register and registered RMII pins.
  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      state_q    <= IDLE_S;
      speed100_q <= 1'b0;
      div_q      <= '0;
      pre_q      <= '0;
      dcnt_q     <= '0;
      last_q     <= '0;
      eop_q      <= 1'b0;
      ifg_q      <= '0;
      shift_q    <= '0;
      rmii_tx_en <= 1'b0;
      rmii_txd   <= 2'b00;
    end else begin
      state_q    <= state_nxt;
      speed100_q <= speed100_nxt;
      div_q      <= div_nxt;
      pre_q      <= pre_nxt;
      dcnt_q     <= dcnt_nxt;
      last_q     <= last_nxt;
      eop_q      <= eop_nxt;
      ifg_q      <= ifg_nxt;
      shift_q    <= shift_nxt;
      rmii_tx_en <= tx_en_nxt;
      rmii_txd   <= txd_nxt;
    end
  end

`ifdef PEG_L2_RMII_TX_STATS_EN
  logic frame_err_q;

  // Saturating frame/underrun/error-frame counters.
  always_ff @(posedge rmii_ref_clk) begin
    if (rst) begin
      frame_err_q        <= 1'b0;
      stat_tx_frames     <= '0;
      stat_tx_underruns  <= '0;
      stat_tx_err_frames <= '0;
    end else begin
      if (start_frame) begin
        frame_err_q <= 1'b0;
      end else if (load_word && pkt_error) begin
        frame_err_q <= 1'b1;
      end
      if (frame_done && (stat_tx_frames != '1)) begin
        stat_tx_frames <= stat_tx_frames + 16'd1;
      end
      if (frame_done && frame_err_q && (stat_tx_err_frames != '1)) begin
        stat_tx_err_frames <= stat_tx_err_frames + 16'd1;
      end
      if (underrun && (stat_tx_underruns != '1)) begin
        stat_tx_underruns <= stat_tx_underruns + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_peg_l2_rs_rmii_tx_sched.sv
// Directed bench for peg_l2_rs_rmii_tx_sched (PKT_DATA_W=64, IFG_DIBITS=48).
module tb_peg_l2_rs_rmii_tx_sched;

  localparam int unsigned W   = 64;
  localparam int unsigned NBW = 3;

  localparam logic [W-1:0] D1 = 64'h0807060504030201;
  localparam logic [W-1:0] D2 = 64'h1122334455667788;
  localparam logic [W-1:0] D3 = 64'hDEADBEEFCAFEBABE;
  localparam logic [W-1:0] DB = 64'hF0E1D2C3B4A59687;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_speed;
  logic           pkt_valid;
  logic           pkt_sop;
  logic           pkt_eop;
  logic [W-1:0]   pkt_data;
  logic [NBW-1:0] pkt_nbytes;
  logic           pkt_error;
  logic           pkt_ready;
  logic           rmii_tx_en;
  logic [1:0]     rmii_txd;
  logic           tx_underrun;
  logic           tx_busy;
`ifdef PEG_L2_RMII_TX_STATS_EN
  logic [15:0]    stat_tx_frames;
  logic [15:0]    stat_tx_underruns;
  logic [15:0]    stat_tx_err_frames;
`endif

  int passed = 0;
  int total  = 0;

  always #10 clk = ~clk;

  peg_l2_rs_rmii_tx_sched #(
    .PKT_DATA_W (W),
    .IFG_DIBITS (48)
  ) dut (
    .rmii_ref_clk                 (clk),
    .rst                          (rst),
    .config_rs_mii_speed_100_n_10 (cfg_speed),
    .pkt_valid                    (pkt_valid),
    .pkt_sop                      (pkt_sop),
    .pkt_eop                      (pkt_eop),
    .pkt_data                     (pkt_data),
    .pkt_nbytes                   (pkt_nbytes),
    .pkt_error                    (pkt_error),
    .pkt_ready                    (pkt_ready),
    .rmii_tx_en                   (rmii_tx_en),
    .rmii_txd                     (rmii_txd),
    .tx_underrun                  (tx_underrun),
    .tx_busy                      (tx_busy)
`ifdef PEG_L2_RMII_TX_STATS_EN
    ,
    .stat_tx_frames               (stat_tx_frames),
    .stat_tx_underruns            (stat_tx_underruns),
    .stat_tx_err_frames           (stat_tx_err_frames)
`endif
  );

  // Pin monitor, sampled on the falling edge.
  int         cyc = 0;
  logic [1:0] dq[$];
  int         rises[$];
  int         falls[$];
  int         ur_cycles[$];
  int         busy_fall = -1;
  int         idle_txd_bad = 0;
  logic       prev_en = 1'b0;
  logic       prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rmii_tx_en === 1'b1) dq.push_back(rmii_txd);
    else if (rmii_txd !== 2'b00) idle_txd_bad = idle_txd_bad + 1;
    if (rmii_tx_en === 1'b1 && !prev_en) rises.push_back(cyc);
    if (rmii_tx_en !== 1'b1 && prev_en) falls.push_back(cyc);
    if (tx_underrun === 1'b1) ur_cycles.push_back(cyc);
    if (tx_busy !== 1'b1 && prev_busy) busy_fall = cyc;
    prev_en   = (rmii_tx_en === 1'b1);
    prev_busy = (tx_busy === 1'b1);
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -100000;
  endfunction

  // Count dibits in dq (from base) that differ from preamble/SFD + data.
  function automatic int frame_errs(input logic [W-1:0] d, input int ndata,
                                    input int hold, input int base);
    int e = 0;
    logic [1:0] exp;
    for (int k = 0; k < 32 + ndata; k++) begin
      if (k < 31)       exp = 2'b01;
      else if (k == 31) exp = 2'b11;
      else              exp = d[2*(k-32) +: 2];
      for (int h = 0; h < hold; h++) begin
        if (base + k*hold + h >= dq.size()) e++;
        else if (dq[base + k*hold + h] !== exp) e++;
      end
    end
    return e;
  endfunction

  task automatic clr_mon();
    dq.delete();
    rises.delete();
    falls.delete();
    ur_cycles.delete();
    busy_fall = -1;
  endtask

  task automatic drive_word(input logic sop, input logic eop, input logic [W-1:0] d,
                            input logic [NBW-1:0] nb, input logic err);
    pkt_valid  = 1'b1;
    pkt_sop    = sop;
    pkt_eop    = eop;
    pkt_data   = d;
    pkt_nbytes = nb;
    pkt_error  = err;
  endtask

  task automatic wait_accept(input string tag, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (pkt_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    pkt_valid = 1'b0;
    pkt_sop   = 1'b0;
    pkt_eop   = 1'b0;
    pkt_error = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
  endtask

  int t0;

  initial begin
    rst        = 1'b1;
    cfg_speed  = 1'b1;
    pkt_valid  = 1'b0;
    pkt_sop    = 1'b0;
    pkt_eop    = 1'b0;
    pkt_data   = '0;
    pkt_nbytes = '0;
    pkt_error  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en",    64'(rmii_tx_en),  64'd0);
    chk("rst_txd",      64'(rmii_txd),    64'd0);
    chk("rst_underrun", 64'(tx_underrun), 64'd0);
    chk("rst_ready",    64'(pkt_ready),   64'd0);
    chk("rst_busy",     64'(tx_busy),     64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 100 Mbps single full word
    clr_mon();
    t0 = cyc;
    drive_word(1'b1, 1'b1, D1, 3'd0, 1'b0);
    wait_accept("f100_accept", 100);
    wait_idle("f100_idle", 300);
    chk("f100_latency",   64'(qget(rises, 0) - t0), 64'd2);
    chk("f100_txen_len",  64'(dq.size()), 64'd64);
    chk("f100_first_dat", 64'((dq.size() > 32) ? dq[32] : 2'bxx), 64'd1);
    chk("f100_dibits",    64'(frame_errs(D1, 32, 1, 0)), 64'd0);
    chk("f100_ifg",       64'(busy_fall - qget(falls, 0)), 64'd48);

    // 10 Mbps same frame, speed config toggled mid-frame
    clr_mon();
    cfg_speed = 1'b0;
    drive_word(1'b1, 1'b1, D1, 3'd0, 1'b0);
    repeat (50) @(posedge clk);
    #1 cfg_speed = 1'b1;
    wait_accept("f10_accept", 400);
    repeat (50) @(posedge clk);
    #1 cfg_speed = 1'b0;
    wait_idle("f10_idle", 1500);
    cfg_speed = 1'b1;
    chk("f10_txen_len", 64'(dq.size()), 64'd640);
    chk("f10_dibits",   64'(frame_errs(D1, 32, 10, 0)), 64'd0);
    chk("f10_ifg",      64'(busy_fall - qget(falls, 0)), 64'd480);

    // 100 Mbps underrun at the word-0 boundary, then drain
    clr_mon();
    drive_word(1'b1, 1'b0, D1, 3'd0, 1'b0);
    wait_accept("ur_accept0", 100);
    repeat (40) @(posedge clk);
    #1;
    chk("ur_pulses",    64'(ur_cycles.size()), 64'd1);
    chk("ur_fall",      64'(qget(falls, 0) - qget(ur_cycles, 0)), 64'd1);
    chk("ur_txen_len",  64'(dq.size()), 64'd64);
    chk("ur_busy_drop", 64'(tx_busy), 64'd1);
    drive_word(1'b0, 1'b1, D2, 3'd0, 1'b0);
    wait_accept("ur_drain_ready", 1);
    wait_idle("ur_idle", 200);
    chk("ur_no_tx_drop", 64'(rises.size()), 64'd1);

    // eop word with 3 valid bytes
    clr_mon();
    drive_word(1'b1, 1'b1, D3, 3'd3, 1'b0);
    wait_accept("nb3_accept", 100);
    wait_idle("nb3_idle", 300);
    chk("nb3_txen_len", 64'(dq.size()), 64'd44);
    chk("nb3_dibits",   64'(frame_errs(D3, 12, 1, 0)), 64'd0);

    // Back-to-back frames, second sop held through the gap
    clr_mon();
    drive_word(1'b1, 1'b1, D1, 3'd0, 1'b0);
    wait_accept("b2b_acceptA", 100);
    drive_word(1'b1, 1'b1, DB, 3'd0, 1'b1);
    wait_accept("b2b_acceptB", 300);
    wait_idle("b2b_idle", 300);
    chk("b2b_rises",   64'(rises.size()), 64'd2);
    chk("b2b_gap",     64'(qget(rises, 1) - qget(falls, 0)), 64'd48);
    chk("b2b_len",     64'(dq.size()), 64'd128);
    chk("b2b_dibitsB", 64'(frame_errs(DB, 32, 1, 64)), 64'd0);

    // Stray non-sop word in idle is consumed and not sent
    clr_mon();
    drive_word(1'b0, 1'b1, D2, 3'd0, 1'b0);
    wait_accept("stray_ready", 1);
    repeat (5) @(posedge clk);
    #1;
    chk("stray_no_tx", 64'(dq.size()), 64'd0);
    chk("stray_busy",  64'(tx_busy), 64'd0);

`ifdef PEG_L2_RMII_TX_STATS_EN
    chk("stat_frames",    64'(stat_tx_frames),     64'd5);
    chk("stat_underruns", 64'(stat_tx_underruns),  64'd1);
    chk("stat_err",       64'(stat_tx_err_frames), 64'd1);
`endif

    // Reset mid-payload
    clr_mon();
    drive_word(1'b1, 1'b1, D1, 3'd0, 1'b0);
    wait_accept("rstm_accept", 100);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstm_tx_en", 64'(rmii_tx_en), 64'd0);
    chk("rstm_ready", 64'(pkt_ready),  64'd0);
    chk("rstm_busy",  64'(tx_busy),    64'd0);
`ifdef PEG_L2_RMII_TX_STATS_EN
    chk("rstm_stat_frames",    64'(stat_tx_frames),     64'd0);
    chk("rstm_stat_underruns", 64'(stat_tx_underruns),  64'd0);
    chk("rstm_stat_err",       64'(stat_tx_err_frames), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // No gap enforced after reset: a new sop starts at once
    clr_mon();
    t0 = cyc;
    drive_word(1'b1, 1'b1, D2, 3'd0, 1'b0);
    wait_accept("post_rst_accept", 100);
    wait_idle("post_rst_idle", 300);
    chk("post_rst_latency", 64'(qget(rises, 0) - t0), 64'd2);
    chk("post_rst_dibits",  64'(frame_errs(D2, 32, 1, 0)), 64'd0);

    chk("txd_zero_when_idle", 64'(idle_txd_bad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
